instruction_queue: RTL

Decoupling queue directly downstream of `instructionFetch`, between fetch and decode. It captures each 56-bit fetch word from `bufferOut` and holds up to `DEPTH` entries. It presents the entries to decode through a valid/ready handshake and drives fetch's `en` as backpressure. On a taken branch it discards all queued and in-flight words so that decode never sees wrong-path instructions.

---
 rtl/iq_pkg.sv | 16 +
 rtl/instruction_queue_if.sv | 32 +++
 rtl/iq_storage.sv | 28 ++
 rtl/instruction_queue.sv | 101 ++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// iq_pkg: shared widths and the fetch-word layout for the instruction queue.
//   PC_W / INSTR_W : field widths of a fetch word
//   FETCH_W        : total fetch-word width (bufferOut)
//   fetch_word_t   : {pc, instr}, bit-identical to instructionFetch bufferOut
package iq_pkg;

    localparam int unsigned PC_W    = 24;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FETCH_W = PC_W + INSTR_W;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_word_t;

endpackage

// File: rtl/instruction_queue_if.sv
// instruction_queue_if: fetch-side and decode-side signals of the queue.
//   bufferOut  : fetch word from instructionFetch
//   fetchEn    : backpressure to fetch en
//   branchFlag : flush request (same net as fetch branchFlag)
//   outValid / outReady / outPc / outInstr : decode handshake and head entry
//   count      : current occupancy
// master = the queue, slave = its environment (fetch + decode).
interface instruction_queue_if #(parameter int unsigned DEPTH = 4);
    import iq_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_word_t        bufferOut;
    logic               fetchEn;
    logic               branchFlag;
    logic               outValid;
    logic               outReady;
    logic [PC_W-1:0]    outPc;
    logic [INSTR_W-1:0] outInstr;
    logic [CNT_W-1:0]   count;

    modport master (
        input  bufferOut, branchFlag, outReady,
        output fetchEn, outValid, outPc, outInstr, count
    );

    modport slave (
        output bufferOut, branchFlag, outReady,
        input  fetchEn, outValid, outPc, outInstr, count
    );

endinterface

// File: rtl/iq_storage.sv
// iq_storage: DEPTH-entry fetch-word register array.
//   clk   : write clock
//   we    : write enable, waddr/wdata : write port
//   raddr : read address, rdata : combinational read data
module iq_storage
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fetch_word_t              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fetch_word_t              rdata
);

    logic [FETCH_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = fetch_word_t'(mem[raddr]);

endmodule

// File: rtl/instruction_queue.sv
// instruction_queue: decoupling queue between instructionFetch and decode.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instruction_queue_if.master (bufferOut, fetchEn, branchFlag,
//              outValid, outReady, outPc, outInstr, count)
// Optional feature: define IQ_BYPASS_EN to present an in-flight word straight
// from bufferOut when the queue is empty (1-edge fetch-to-decode latency).
module instruction_queue
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_queue_if.master  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] cnt;
    logic             inflight;
    logic             empty;
    logic             bypassSel;
    logic             push;
    logic             pop;
    logic             fetchEnInt;
    logic [CNT_W:0]   reserved;
    fetch_word_t      headWord;

    assign empty = (cnt == '0);

    // Slots already owned: stored entries plus the word fetch is producing.
    // Pops are deliberately not credited, so overflow cannot occur.
    assign reserved   = {1'b0, cnt} + {{CNT_W{1'b0}}, inflight};
    assign fetchEnInt = !rst && !bus.branchFlag && (reserved < (CNT_W+1)'(DEPTH));

`ifdef IQ_BYPASS_EN
    assign bypassSel = empty && inflight;
`else
    assign bypassSel = 1'b0;
`endif

    // A bypassed word accepted by decode is consumed and never stored.
    assign push = inflight && !bus.branchFlag && !(bypassSel && bus.outReady);
    assign pop  = !empty && bus.outReady && !bus.branchFlag;

    iq_storage #(.DEPTH(DEPTH)) storage (
        .clk   (clk),
        .we    (push),
        .waddr (wrPtr),
        .wdata (bus.bufferOut),
        .raddr (rdPtr),
        .rdata (headWord)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
        end else if (bus.branchFlag) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fetchEnInt;
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.outPc    = '0;
        bus.outInstr = '0;
        if (!empty) begin
            bus.outPc    = headWord.pc;
            bus.outInstr = headWord.instr;
        end else if (bypassSel) begin
            bus.outPc    = bus.bufferOut.pc;
            bus.outInstr = bus.bufferOut.instr;
        end
    end

    assign bus.outValid = !empty || (bypassSel && !bus.branchFlag);
    assign bus.fetchEn  = fetchEnInt;
    assign bus.count    = cnt;

endmodule
